aes_tiled_lanes: RTL and testbench
==================================

AES_TILED_LANES -- requirements
Module: aes_tiled_lanes

Interface
REQ-001 The block SHALL have parameter LANES, default 1, which sets the number of byte-lanes evaluated per cycle (legal values 1, 2, 4).
REQ-002 g_clk  in  1  The single clock; all state SHALL change on its rising edge.
REQ-003 g_resetn  in  1  Reset, synchronous, active-low.
REQ-004 valid  in  1  Request valid; sampled only while idle.
REQ-005 dec  in  1  0 = encrypt, 1 = decrypt.
REQ-006 op_sb  in  1  SubBytes, all four bytes of rs1.
REQ-007 op_sbsr  in  1  SubBytes plus ShiftRows half-state.
REQ-008 op_mix  in  1  MixColumns byte-pairs.
REQ-009 hi  in  1  Selects the high ShiftRows half.
REQ-010 rs1, rs2  in  32 each  Source operands.
REQ-011 busy  out  1  Request accepted and not yet complete.
REQ-012 ready  out  1  One-cycle pulse: rd valid.
REQ-013 rd  out  32  Result, held stable until the next accept.

Function
REQ-014 Accept SHALL occur when valid=1 in IDLE; dec, op_*, hi, rs1 and rs2 SHALL be captured at accept, and later input changes SHALL NOT affect the result.
REQ-015 FSM states: IDLE -> RUN on accept; RUN -> DONE after STEPS=4/LANES cycles; DONE -> IDLE unconditionally.
REQ-016 A step counter (width clog2(4) bits) SHALL clear at accept and increment each RUN cycle; it SHALL evaluate result bytes [LANES*step .. LANES*step+LANES-1].
REQ-017 ready SHALL be 1 only in DONE; busy SHALL be 1 in RUN and DONE; latency from the accept edge to ready is STEPS+1 cycles (LANES=1: 5, LANES=2: 3, LANES=4: 2).
REQ-018 valid in RUN or DONE SHALL be ignored; back-to-back requests SHALL be accepted from the cycle after DONE.
REQ-019 The result register SHALL be written byte-wise during RUN; rd SHALL equal the final result from DONE onward and SHALL hold it through IDLE.
REQ-020 op_sb: rd byte i = S(rs1 byte i) when dec=0, and Sinv(rs1 byte i) when dec=1 (the inverse form is new behaviour).
REQ-021 op_sbsr, dec=0, bytes 3..0: hi=0 gives {S(rs1.b1), S(rs1.b2), S(rs2.b3), S(rs1.b0)}; hi=1 gives {S(rs2.b1), S(rs2.b2), S(rs1.b3), S(rs2.b0)}.
REQ-022 op_sbsr, dec=1, bytes 3..0: hi=0 gives {Si(rs2.b1), Si(rs1.b2), Si(rs1.b3), Si(rs1.b0)}; hi=1 gives {Si(rs1.b1), Si(rs2.b2), Si(rs2.b3), Si(rs2.b0)}.
REQ-023 op_mix uses c0={rs1.b2, rs1.b3, rs2.b2, rs2.b3} and c1={rs1.b0, rs1.b1, rs2.b0, rs2.b1}; rot(x) rotates x left by one byte; M is the mixcolumn-byte function (inverse when dec=1). rd = {M(rot c0), M(c0), M(rot c1), M(c1)}.
REQ-024 Priority SHALL be op_mix > op_sb > op_sbsr; if no op bit is set, the request SHALL complete with normal timing and rd=0.
REQ-025 hi SHALL be ignored for op_sb and op_mix.

Reset
REQ-026 While g_resetn=0 at a clock edge: FSM=IDLE, counter=0, rd=0, ready=0, busy=0.
REQ-027 Reset during RUN or DONE SHALL abort the operation without a ready pulse; a valid held high during reset SHALL NOT be accepted until the first edge with g_resetn=1.

Structure
REQ-028 A shared package SHALL hold the FSM state encodings, the legal-LANES check and the op-priority decode constant; an illegal LANES SHALL cause an elaboration error.
REQ-029 One sub-module, aes_tiled_lane, SHALL be instantiated LANES times; each lane SHALL contain a forward S-box, an inverse S-box and a mixcolumn-byte unit, with an 8-bit output selected by op/dec.

Verification
REQ-030 LANES=1: op_sb, dec=0, rs1=0x00000053 -> rd=0x636363ED, ready exactly 5 cycles after accept.
REQ-031 LANES=4: op_sb, dec=1, rs1=0x63636363 -> rd=0x00000000 with ready 2 cycles after accept; rs1 changed to 0xFFFFFFFF the cycle after accept has no effect on rd.
REQ-032 All LANES values: op_mix, dec=0, c0 column db,13,53,45 -> result bytes include 8e,4d,a1,bc per REQ-023; dec=1 on those outputs recovers db,13,53,45.
REQ-033 op_sbsr for both hi values and both dec values with rs1=0x03020100 and rs2=0x07060504 -> byte placement matches REQ-021/022.
REQ-034 Reset asserted mid-RUN -> no ready pulse, rd=0, busy=0; valid during RUN ignored; back-to-back requests are accepted in consecutive IDLE windows.
REQ-035 No op bit set -> rd=0 with normal latency; multiple op bits set -> priority per REQ-024.

Source files
------------

// File: rtl/aes_tiled_lanes_pkg.sv
// Shared types and GF(2^8) helpers for the tiled AES byte-lane unit.
package aes_tiled_lanes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_SB   = 2'd1,
    OP_SBSR = 2'd2,
    OP_MIX  = 2'd3
  } op_e;

  localparam int NBYTES = 4;
  localparam int STEP_W = $clog2(NBYTES);

  // Indexed by {op_mix, op_sb, op_sbsr}: mix beats sb beats sbsr.
  localparam op_e OP_DECODE [8] = '{OP_NONE, OP_SBSR, OP_SB, OP_SB,
                                    OP_MIX, OP_MIX, OP_MIX, OP_MIX};

  function automatic logic lanes_legal(int lanes);
    return (lanes == 1) || (lanes == 2) || (lanes == 4);
  endfunction

  function automatic logic [7:0] rotl8(logic [7:0] x, int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  function automatic logic [7:0] xtime(logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = '0;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // a^254 is the multiplicative inverse, and conveniently maps 0 to 0.
  function automatic logic [7:0] gf_inv(logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox_fwd(logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(logic [7:0] x);
    return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] mix_byte(logic [31:0] c, logic inv);
    if (inv)
      return gf_mul(c[7:0], 8'h0e) ^ gf_mul(c[15:8], 8'h0b) ^
             gf_mul(c[23:16], 8'h0d) ^ gf_mul(c[31:24], 8'h09);
    return gf_mul(c[7:0], 8'h02) ^ gf_mul(c[15:8], 8'h03) ^ c[23:16] ^ c[31:24];
  endfunction

endpackage

// File: rtl/aes_tiled_lanes_lane.sv
// One byte lane: forward/inverse S-box and mixcolumn-byte, output picked by op/dec.
module aes_tiled_lane
  import aes_tiled_lanes_pkg::*;
(
  input  op_e         op,
  input  logic        dec,
  input  logic [7:0]  sb_in,
  input  logic [31:0] mix_col,
  output logic [7:0]  res
);

  logic [7:0] sb_f;
  logic [7:0] sb_i;
  logic [7:0] mix_o;

  always_comb begin
    sb_f  = sbox_fwd(sb_in);
    sb_i  = sbox_inv(sb_in);
    mix_o = mix_byte(mix_col, dec);
    case (op)
      OP_MIX:          res = mix_o;
      OP_SB, OP_SBSR:  res = dec ? sb_i : sb_f;
      default:         res = 8'h00;
    endcase
  end

endmodule

// File: rtl/aes_tiled_lanes.sv
// Multi-cycle AES byte operations, LANES result bytes produced per RUN cycle.
module aes_tiled_lanes
  import aes_tiled_lanes_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        valid,
  input  logic        dec,
  input  logic        op_sb,
  input  logic        op_sbsr,
  input  logic        op_mix,
  input  logic        hi,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        busy,
  output logic        ready,
  output logic [31:0] rd
);

  localparam int STEPS = NBYTES / LANES;

  if (!lanes_legal(LANES)) begin : g_bad_lanes
    $error("aes_tiled_lanes: LANES must be 1, 2 or 4");
  end

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  op_e                 op_q, op_d;
  logic                dec_q, dec_d, hi_q, hi_d;
  logic [31:0]         rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic                ready_q, ready_d, busy_q, busy_d;

  logic [STEP_W-1:0]   lane_idx [LANES];
  logic [7:0]          lane_sb  [LANES];
  logic [31:0]         lane_col [LANES];
  logic [7:0]          lane_res [LANES];
  logic [31:0]         c0, c1;

  // Operand routing for the result byte each lane owns this step.
  always_comb begin
    c0 = {rs1_q[23:16], rs1_q[31:24], rs2_q[23:16], rs2_q[31:24]};
    c1 = {rs1_q[7:0], rs1_q[15:8], rs2_q[7:0], rs2_q[15:8]};
    for (int l = 0; l < LANES; l++) begin
      lane_idx[l] = STEP_W'(LANES * int'(step_q) + l);
      if (op_q == OP_SB)
        lane_sb[l] = rs1_q[{lane_idx[l], 3'b000} +: 8];
      else if (hi_q ^ (lane_idx[l] == (dec_q ? 2'd3 : 2'd1)))
        lane_sb[l] = rs2_q[{STEP_W'(2'd0 - lane_idx[l]), 3'b000} +: 8];
      else
        lane_sb[l] = rs1_q[{STEP_W'(2'd0 - lane_idx[l]), 3'b000} +: 8];
      lane_col[l] = lane_idx[l][1] ? c0 : c1;
      if (lane_idx[l][0]) lane_col[l] = {lane_col[l][23:0], lane_col[l][31:24]};
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    aes_tiled_lane u_lane (
      .op      (op_q),
      .dec     (dec_q),
      .sb_in   (lane_sb[l]),
      .mix_col (lane_col[l]),
      .res     (lane_res[l])
    );
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    op_d    = op_q;
    dec_d   = dec_q;
    hi_d    = hi_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    case (state_q)
      ST_IDLE: if (valid) begin
        state_d = ST_RUN;
        step_d  = '0;
        op_d    = OP_DECODE[{op_mix, op_sb, op_sbsr}];
        dec_d   = dec;
        hi_d    = hi;
        rs1_d   = rs1;
        rs2_d   = rs2;
        rd_d    = '0;
      end
      ST_RUN: begin
        for (int l = 0; l < LANES; l++) rd_d[{lane_idx[l], 3'b000} +: 8] = lane_res[l];
        step_d = step_q + STEP_W'(1);
        if (step_q == STEP_W'(STEPS - 1)) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_DONE);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      op_q    <= OP_NONE;
      dec_q   <= 1'b0;
      hi_q    <= 1'b0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      op_q    <= op_d;
      dec_q   <= dec_d;
      hi_q    <= hi_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign busy  = busy_q;
  assign ready = ready_q;
  assign rd    = rd_q;

endmodule

// File: tb/tb_aes_tiled_lanes.sv
// Bench for aes_tiled_lanes: LANES=1,2,4 side by side against a table-driven AES model.
module tb_aes_tiled_lanes;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        g_resetn, valid, dec, op_sb, op_sbsr, op_mix, hi;
  logic [31:0] rs1, rs2;
  logic [2:0]  busy_w, ready_w;
  logic [31:0] rd_w [3];

  int total = 0;
  int bad   = 0;
  localparam int NSTEP [3] = '{4, 2, 1};

  logic [7:0] sbox [256];
  logic [7:0] isbox [256];
  logic [7:0] exp_t [256];
  int         log_t [256];

  logic        r_m, r_s, r_sr, r_d, r_h;
  logic [31:0] r_a, r_b, r_exp;

  aes_tiled_lanes #(.LANES(1)) dut1 (
    .g_clk(clk), .g_resetn(g_resetn), .valid(valid), .dec(dec), .op_sb(op_sb),
    .op_sbsr(op_sbsr), .op_mix(op_mix), .hi(hi), .rs1(rs1), .rs2(rs2),
    .busy(busy_w[0]), .ready(ready_w[0]), .rd(rd_w[0]));
  aes_tiled_lanes #(.LANES(2)) dut2 (
    .g_clk(clk), .g_resetn(g_resetn), .valid(valid), .dec(dec), .op_sb(op_sb),
    .op_sbsr(op_sbsr), .op_mix(op_mix), .hi(hi), .rs1(rs1), .rs2(rs2),
    .busy(busy_w[1]), .ready(ready_w[1]), .rd(rd_w[1]));
  aes_tiled_lanes #(.LANES(4)) dut4 (
    .g_clk(clk), .g_resetn(g_resetn), .valid(valid), .dec(dec), .op_sb(op_sb),
    .op_sbsr(op_sbsr), .op_mix(op_mix), .hi(hi), .rs1(rs1), .rs2(rs2),
    .busy(busy_w[2]), .ready(ready_w[2]), .rd(rd_w[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rot8(logic [7:0] v, int n);
    logic [15:0] t;
    t = {v, v};
    return t[15-n -: 8];
  endfunction

  task automatic build_tables();
    logic [7:0] p, q, x, e;
    p = 8'h01;
    q = 8'h01;
    repeat (255) begin
      p = p ^ 8'(p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ 8'(q << 1);
      q = q ^ 8'(q << 2);
      q = q ^ 8'(q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rot8(q, 1) ^ rot8(q, 2) ^ rot8(q, 3) ^ rot8(q, 4);
      sbox[p] = x ^ 8'h63;
    end
    sbox[0] = 8'h63;
    for (int i = 0; i < 256; i++) isbox[sbox[i]] = 8'(i);
    e = 8'h01;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = e;
      log_t[e] = i;
      e = e ^ 8'(e << 1) ^ (e[7] ? 8'h1b : 8'h00);
    end
  endtask

  function automatic logic [7:0] gm(logic [7:0] a, logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return exp_t[(log_t[a] + log_t[b]) % 255];
  endfunction

  function automatic logic [7:0] mixb(logic [31:0] c, logic d);
    if (d) return gm(c[7:0], 8'h0e) ^ gm(c[15:8], 8'h0b) ^ gm(c[23:16], 8'h0d) ^ gm(c[31:24], 8'h09);
    return gm(c[7:0], 8'h02) ^ gm(c[15:8], 8'h03) ^ c[23:16] ^ c[31:24];
  endfunction

  function automatic logic [31:0] rotw(logic [31:0] x);
    return {x[23:0], x[31:24]};
  endfunction

  function automatic logic [31:0] model(logic m, logic s, logic sr, logic d, logic h,
                                        logic [31:0] a, logic [31:0] b);
    logic [7:0]  x [4];
    logic [7:0]  y [4];
    logic [7:0]  r [4];
    logic [31:0] c0, c1;
    for (int i = 0; i < 4; i++) begin
      x[i] = a[8*i +: 8];
      y[i] = b[8*i +: 8];
      r[i] = d ? isbox[x[i]] : sbox[x[i]];
    end
    c0 = {x[2], x[3], y[2], y[3]};
    c1 = {x[0], x[1], y[0], y[1]};
    if (m) return {mixb(rotw(c0), d), mixb(c0, d), mixb(rotw(c1), d), mixb(c1, d)};
    if (s) return {r[3], r[2], r[1], r[0]};
    if (sr && !d)
      return h ? {sbox[y[1]], sbox[y[2]], sbox[x[3]], sbox[y[0]]}
               : {sbox[x[1]], sbox[x[2]], sbox[y[3]], sbox[x[0]]};
    if (sr)
      return h ? {isbox[x[1]], isbox[y[2]], isbox[y[3]], isbox[y[0]]}
               : {isbox[y[1]], isbox[x[2]], isbox[x[3]], isbox[x[0]]};
    return 32'h0;
  endfunction

  // One request; operands are scrambled right after the accept edge.
  task automatic run_req(input string tag, input logic m, input logic s, input logic sr,
                         input logic d, input logic h, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    int lat [3];
    int pulses [3];
    for (int k = 0; k < 3; k++) begin
      lat[k] = 0;
      pulses[k] = 0;
    end
    op_mix = m; op_sb = s; op_sbsr = sr; dec = d; hi = h; rs1 = a; rs2 = b;
    valid = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        valid = 1'b0;
        rs1 = 32'hffff_ffff;
        rs2 = $urandom;
        dec = ~d; hi = ~h; op_mix = ~m; op_sb = ~s; op_sbsr = ~sr;
      end
      for (int k = 0; k < 3; k++)
        if (ready_w[k]) begin
          pulses[k]++;
          if (lat[k] == 0) lat[k] = n;
        end
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_lat_l%0d", tag, k), 32'(lat[k]), 32'(NSTEP[k] + 1));
      chk($sformatf("%s_pulses_l%0d", tag, k), 32'(pulses[k]), 32'd1);
      chk($sformatf("%s_rd_l%0d", tag, k), rd_w[k], exp);
      chk($sformatf("%s_busy_l%0d", tag, k), 32'(busy_w[k]), 32'd0);
    end
  endtask

  initial begin
    build_tables();
    g_resetn = 1'b0; valid = 1'b0; dec = 1'b0; op_sb = 1'b0; op_sbsr = 1'b0;
    op_mix = 1'b0; hi = 1'b0; rs1 = '0; rs2 = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_rd_l%0d", k), rd_w[k], 32'h0);
      chk($sformatf("rst_busy_l%0d", k), 32'(busy_w[k]), 32'd0);
      chk($sformatf("rst_ready_l%0d", k), 32'(ready_w[k]), 32'd0);
    end
    g_resetn = 1'b1;
    @(posedge clk); #1;

    run_req("sb_enc", 0, 1, 0, 0, 0, 32'h0000_0053, 32'h0, 32'h6363_63ed);
    run_req("sb_dec", 0, 1, 0, 1, 0, 32'h6363_6363, 32'h0, 32'h0000_0000);
    run_req("mix_enc", 1, 0, 0, 0, 0, 32'h5345_db13, 32'hdb13_5345, 32'hbc8e_4da1);
    run_req("mix_enc_hi", 1, 0, 0, 0, 1, 32'h5345_db13, 32'hdb13_5345, 32'hbc8e_4da1);
    run_req("mix_dec", 1, 0, 0, 1, 0, 32'ha1bc_8e4d, 32'h8e4d_a1bc, 32'h45db_1353);
    for (int v = 0; v < 4; v++) begin
      r_d = v[1]; r_h = v[0];
      r_exp = model(0, 0, 1, r_d, r_h, 32'h0302_0100, 32'h0706_0504);
      run_req($sformatf("sbsr_d%0d_h%0d", r_d, r_h), 0, 0, 1, r_d, r_h,
              32'h0302_0100, 32'h0706_0504, r_exp);
    end
    run_req("no_op", 0, 0, 0, 0, 1, 32'hdead_beef, 32'h1234_5678, 32'h0);
    r_exp = model(1, 1, 1, 0, 0, 32'h0302_0100, 32'h0706_0504);
    run_req("prio_all", 1, 1, 1, 0, 0, 32'h0302_0100, 32'h0706_0504, r_exp);
    r_exp = model(0, 1, 1, 1, 1, 32'h0302_0100, 32'h0706_0504);
    run_req("prio_sb_sbsr", 0, 1, 1, 1, 1, 32'h0302_0100, 32'h0706_0504, r_exp);

    for (int i = 0; i < 24; i++) begin
      r_m = 1'($urandom_range(0, 1)); r_s = 1'($urandom_range(0, 1));
      r_sr = 1'($urandom_range(0, 1)); r_d = 1'($urandom_range(0, 1));
      r_h = 1'($urandom_range(0, 1)); r_a = $urandom; r_b = $urandom;
      r_exp = model(r_m, r_s, r_sr, r_d, r_h, r_a, r_b);
      run_req($sformatf("rand%0d", i), r_m, r_s, r_sr, r_d, r_h, r_a, r_b, r_exp);
    end

    // Reset right after accept, with valid held through reset.
    r_a = $urandom;
    op_mix = 1'b0; op_sb = 1'b1; op_sbsr = 1'b0; dec = 1'b0; hi = 1'b0; rs1 = r_a; rs2 = '0;
    valid = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) chk($sformatf("mid_busy_l%0d", k), 32'(busy_w[k]), 32'd1);
    g_resetn = 1'b0;
    for (int n = 0; n < 2; n++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("abort_ready_l%0d_c%0d", k, n), 32'(ready_w[k]), 32'd0);
        chk($sformatf("abort_busy_l%0d_c%0d", k, n), 32'(busy_w[k]), 32'd0);
        chk($sformatf("abort_rd_l%0d_c%0d", k, n), rd_w[k], 32'h0);
      end
    end
    g_resetn = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) chk($sformatf("post_rst_acc_l%0d", k), 32'(busy_w[k]), 32'd1);
    valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++)
      chk($sformatf("post_rst_rd_l%0d", k), rd_w[k], model(0, 1, 0, 0, 0, r_a, 32'h0));

    // valid held high: ignored in RUN/DONE, re-accepted in each IDLE window.
    r_a = $urandom; r_b = $urandom;
    op_mix = 1'b1; op_sb = 1'b0; op_sbsr = 1'b0; dec = 1'b1; hi = 1'b0; rs1 = r_a; rs2 = r_b;
    valid = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++)
        chk($sformatf("b2b_ready_l%0d_c%0d", k, n), 32'(ready_w[k]),
            32'((n >= NSTEP[k] + 1) && ((n - NSTEP[k] - 1) % (NSTEP[k] + 2) == 0)));
    end
    valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++)
      chk($sformatf("b2b_rd_l%0d", k), rd_w[k], model(1, 0, 0, 1, 0, r_a, r_b));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "bench did not finish");
  end

endmodule
